rob_tag_alloc: RTL
==================

# rob_tag_alloc

Issue-side allocator for reorder-buffer slots. Hands out ROB indices to instructions in program order at decode/issue and tracks the in-flight window between the allocation tail and the commit head. Stalls issue when every slot is in flight and frees one slot per ROB commit. It is the producer of the robIdx tags the ROB later receives on its four write-back ports, and it is flushed by the same clear that empties the ROB.

## Interface

Parameters:
- ROB_SLOTS, 16, number of ROB entries; power of two.
- ROB_IDX_BITS, 4, log2(ROB_SLOTS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  pipeline flush on exception/redirect, synchronous; same cycle the ROB sees clear.
- alloc_req  in  1  decode wants a slot for the current instruction.
- alloc_ready  out  1  a slot is free this cycle.
- alloc_idx  out  ROB_IDX_BITS  index granted when alloc_req && alloc_ready (the fire condition).
- commit  in  1  the ROB head retired this cycle (the ROB's head-valid signal).
- commit_idx  in  ROB_IDX_BITS  the ROB head index that retired; checked against the internal head.
- head_idx  out  ROB_IDX_BITS  oldest in-flight slot.
- count  out  ROB_IDX_BITS+1  slots in flight, 0..ROB_SLOTS.
- empty  out  1  count == 0.
- full  out  1  count == ROB_SLOTS.
- busy  out  ROB_SLOTS  per-slot in-flight mask.
- err  out  1  sticky protocol error.

## Operation

- State: tail, head (ROB_IDX_BITS each), count (ROB_IDX_BITS+1), busy[ROB_SLOTS], err.
- Combinational outputs:
  - alloc_idx = tail.
  - alloc_ready = !full. There is no same-cycle bypass from commit, so a commit in a full cycle does not allow an allocation in that same cycle.
  - empty and full are decoded from count.
- Allocation fire (alloc_req && alloc_ready):
  - busy[tail] <= 1.
  - tail <= tail+1, wrapping ROB_SLOTS-1 -> 0 (natural width overflow).
- Valid commit (commit && !empty):
  - busy[head] <= 0.
  - head <= head+1 with the same wrap.
- Error conditions, each setting err <= 1 (sticky):
  - Valid commit with commit_idx != head. The pointers still advance.
  - commit while empty. This commit is otherwise ignored: head, count and busy are unchanged.
- count update:
  - +1 on fire only.
  - -1 on valid commit only.
  - Unchanged when both occur in the same cycle.
- clear: tail, head, count and busy go to 0, and err is held. Clear overrides fire and commit in the same cycle.
- rst: as clear, and err is also cleared. rst has priority over everything.
- alloc_req while full: no state change, alloc_ready = 0. Decode must hold the request; the request is not dropped silently.
- Invariant: popcount(busy) == count, and busy is set exactly for the slots from head up to, but not including, tail (mod ROB_SLOTS).

## Timing

- Reset values (cycle after rst=1):
  - head_idx = 0, alloc_idx = 0, count = 0.
  - empty = 1, full = 0, alloc_ready = 1.
  - busy = 0, err = 0.
- Allocation latency is 0: the index is valid in the same cycle as the fire. The next index is visible the following cycle.
- Commit frees a slot at the next edge. alloc_ready rises one cycle after the commit that drains a full buffer.
- Throughput: one allocation and one commit per cycle sustained.
- After clear, the first allocation may occur the very next cycle and receives index 0, matching the ROB head reset to 0.
- Reset or clear asserted mid-burst: the fire in that cycle is discarded. Decode must treat that index as not issued.

## Test plan

- Reset, then alloc_req=1 for 16 cycles with no commit -> alloc_idx 0..15 in order; full=1 and alloc_ready=0 after the 16th; count=16; busy=16'hFFFF.
- From full, pulse commit with commit_idx=0, alloc_req held -> the same cycle gives no fire; the next cycle gives alloc_ready=1 and alloc_idx=0 (wrap); head_idx=1; count returns to 16.
- With count=8, alloc and commit together for 20 cycles with matching commit_idx -> count stays 8; head and tail wrap past 15 to 0 cleanly; busy popcount stays 8.
- Allocate 5, assert clear together with alloc_req and commit -> next cycle count=0, head_idx=0, alloc_idx=0, busy=0; err is unchanged.
- Commit while empty -> err=1, count stays 0, head_idx stays 0. Then clear -> err stays 1. Then rst -> err=0.
- Allocate 3, commit with commit_idx=2 while head=0 -> err=1, head_idx=1, count=2.

Source files
------------

// File: rtl/rob_tag_alloc.sv
// Reorder-buffer slot allocator: hands out ROB indices in program order
// and tracks the in-flight window between commit head and allocation tail.
module rob_tag_alloc #(
   parameter int ROB_SLOTS    = 16,
   parameter int ROB_IDX_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    alloc_req,
   output logic                    alloc_ready,
   output logic [ROB_IDX_BITS-1:0] alloc_idx,
   input  logic                    commit,
   input  logic [ROB_IDX_BITS-1:0] commit_idx,
   output logic [ROB_IDX_BITS-1:0] head_idx,
   output logic [ROB_IDX_BITS:0]   count,
   output logic                    empty,
   output logic                    full,
   output logic [ROB_SLOTS-1:0]    busy,
   output logic                    err
);

   localparam logic [ROB_IDX_BITS:0] FULL_CNT = ROB_SLOTS[ROB_IDX_BITS:0];

   logic [ROB_IDX_BITS-1:0] tail_q;
   logic [ROB_IDX_BITS-1:0] head_q;
   logic [ROB_IDX_BITS:0]   cnt_q;
   logic [ROB_SLOTS-1:0]    busy_q;
   logic                    err_q;

   logic fire;
   logic cvalid;
   logic bad_commit;

   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == FULL_CNT);
   // No commit bypass: a full buffer stays closed for the whole cycle.
   assign alloc_ready = !full;
   assign alloc_idx   = tail_q;
   assign head_idx    = head_q;
   assign count       = cnt_q;
   assign busy        = busy_q;
   assign err         = err_q;

   assign fire       = alloc_req && alloc_ready;
   assign cvalid     = commit && !empty;
   assign bad_commit = (commit && empty) || (cvalid && (commit_idx != head_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         tail_q <= '0;
         head_q <= '0;
         cnt_q  <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else if (clear) begin
         tail_q <= '0;
         head_q <= '0;
         cnt_q  <= '0;
         busy_q <= '0;
      end else begin
         // head and tail only coincide when empty or full, so the
         // set and clear below never target the same slot.
         if (fire) begin
            busy_q[tail_q] <= 1'b1;
            tail_q         <= tail_q + 1'b1;
         end
         if (cvalid) begin
            busy_q[head_q] <= 1'b0;
            head_q         <= head_q + 1'b1;
         end
         if (fire && !cvalid) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (cvalid && !fire) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (bad_commit) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
